// File: rtl/inst_queue.sv
// inst_queue: circular FIFO of decoded instructions between decoder and forward stage.
// The head entry is presented combinationally. A pop happens when the forward stage is ready.
module inst_queue #(
    parameter int unsigned DEPTH_LOG = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_i,
    input  logic                 flush_i,
    input  logic                 push_valid_i,
    input  logic                 push_is_vec_i,
    input  logic [1:0]           push_type_i,
    input  logic [5:0]           push_name_i,
    input  logic [4:0]           push_rd_i,
    input  logic [31:0]          push_pc_i,
    input  logic [31:0]          push_imm_i,
    output logic                 full_o,
    output logic [DEPTH_LOG:0]   count_o,
    input  logic                 ins_rdy_i,
    output logic                 issue_rdy_o,
    output logic                 is_vec_o,
    output logic [1:0]           type_o,
    output logic [5:0]           name_o,
    output logic [4:0]           rd_o,
    output logic [31:0]          pc_o,
    output logic [31:0]          imm_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;
    localparam int unsigned CW    = DEPTH_LOG + 1;

    typedef struct packed {
        logic        is_vec;
        logic [1:0]  typ;
        logic [5:0]  name;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
    } entry_t;

    entry_t                 mem_q [DEPTH];
    logic [DEPTH_LOG-1:0]   head_q, head_d;
    logic [DEPTH_LOG-1:0]   tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   empty_c;
    logic                   push_c;
    logic                   pop_c;
    entry_t                 push_entry_c;
    entry_t                 head_entry_c;

    // Occupancy flags, handshake qualifiers and head-entry fields
    always_comb begin
        empty_c      = (count_q == '0);
        full_o       = (count_q == CW'(DEPTH));
        count_o      = count_q;
        issue_rdy_o  = !empty_c && ins_rdy_i && !flush_i;
        pop_c        = issue_rdy_o && rdy_i;
        push_c       = push_valid_i && !full_o && !flush_i && rdy_i;
        push_entry_c = '{is_vec: push_is_vec_i, typ: push_type_i, name: push_name_i,
                         rd: push_rd_i, pc: push_pc_i, imm: push_imm_i};
        head_entry_c = mem_q[head_q];
        is_vec_o     = head_entry_c.is_vec;
        type_o       = head_entry_c.typ;
        name_o       = head_entry_c.name;
        rd_o         = head_entry_c.rd;
        pc_o         = head_entry_c.pc;
        imm_o        = head_entry_c.imm;
    end

    // Next-state for pointers and count; flush wins over push/pop
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_i) begin
            if (flush_i) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push_c) tail_d = tail_q + DEPTH_LOG'(1);
                if (pop_c)  head_d = head_q + DEPTH_LOG'(1);
                if (push_c && !pop_c)      count_d = count_q + CW'(1);
                else if (pop_c && !push_c) count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and count registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (!rst && push_c) mem_q[tail_q] <= push_entry_c;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus pushes expected entries, monitor checks issues.
module tb_inst_queue;

    localparam logic [1:0] ALU = 2'd0;
    localparam logic [1:0] MEM = 2'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        push_valid_i = 1'b0;
    logic        push_is_vec_i = 1'b0;
    logic [1:0]  push_type_i = '0;
    logic [5:0]  push_name_i = '0;
    logic [4:0]  push_rd_i = '0;
    logic [31:0] push_pc_i = '0;
    logic [31:0] push_imm_i = '0;
    logic        full_o;
    logic [3:0]  count_o;
    logic        ins_rdy_i;
    logic        issue_rdy_o;
    logic        is_vec_o;
    logic [1:0]  type_o;
    logic [5:0]  name_o;
    logic [4:0]  rd_o;
    logic [31:0] pc_o;
    logic [31:0] imm_o;

    logic        ins_req = 1'b0;
    logic        stall_q = 1'b0;

    logic [77:0] sb [$];
    int          errors = 0;
    int          checks = 0;
    int          n_issued = 0;

    inst_queue #(.DEPTH_LOG(3)) dut (
        .clk(clk), .rst(rst), .rdy_i(rdy_i), .flush_i(flush_i),
        .push_valid_i(push_valid_i), .push_is_vec_i(push_is_vec_i),
        .push_type_i(push_type_i), .push_name_i(push_name_i), .push_rd_i(push_rd_i),
        .push_pc_i(push_pc_i), .push_imm_i(push_imm_i),
        .full_o(full_o), .count_o(count_o), .ins_rdy_i(ins_rdy_i),
        .issue_rdy_o(issue_rdy_o), .is_vec_o(is_vec_o), .type_o(type_o),
        .name_o(name_o), .rd_o(rd_o), .pc_o(pc_o), .imm_o(imm_o)
    );

    always #5 clk = ~clk;

    // Forward-stage model: drop ready for the cycle after a memory-op issue
    always @(posedge clk) begin
        if (rst) stall_q <= 1'b0;
        else if (rdy_i) stall_q <= issue_rdy_o && (type_o == MEM);
    end
    assign ins_rdy_i = ins_req && !stall_q;

    function automatic logic [77:0] mk(input logic [31:0] pc, input logic [1:0] typ);
        return {pc[2], typ, pc[7:2], pc[6:2], pc, pc ^ 32'hA5A5_0000};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one push for one cycle; record it in the scoreboard if it should be accepted
    task automatic push_one(input logic [31:0] pc, input logic [1:0] typ, input bit accepted);
        logic [77:0] e;
        e = mk(pc, typ);
        {push_is_vec_i, push_type_i, push_name_i, push_rd_i, push_pc_i, push_imm_i} = e;
        push_valid_i = 1'b1;
        if (accepted) sb.push_back(e);
        tick();
        push_valid_i = 1'b0;
    endtask

    // Monitor: every real issue must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && rdy_i && issue_rdy_o) begin
            logic [77:0] got;
            got = {is_vec_o, type_o, name_o, rd_o, pc_o, imm_o};
            checks++;
            n_issued++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got pc 0x%0h expected no issue", pc_o);
            end else begin
                logic [77:0] exp;
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL issue_entry: got pc 0x%0h (entry 0x%0h) expected pc 0x%0h (entry 0x%0h)",
                             pc_o, got, exp[63:32], exp);
                end
            end
        end
    end

    initial begin
        // Reset then idle
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_count", 32'(count_o), 0);
        check("reset_full", 32'(full_o), 0);
        check("reset_issue", 32'(issue_rdy_o), 0);
        ins_req = 1'b1;
        tick();
        check("idle_issue", 32'(issue_rdy_o), 0);

        // Fill to full, drop the 9th push, then drain in order
        ins_req = 1'b0;
        for (int i = 0; i < 8; i++) push_one(32'(i * 4), ALU, 1'b1);
        check("fill_count", 32'(count_o), 8);
        check("fill_full", 32'(full_o), 1);
        push_one(32'h20, ALU, 1'b0);
        check("drop_count", 32'(count_o), 8);
        check("drop_full", 32'(full_o), 1);
        ins_req = 1'b1;
        repeat (8) tick();
        check("drain_count", 32'(count_o), 0);
        check("drain_full", 32'(full_o), 0);

        // Stream 20 entries at steady occupancy 3 across pointer wrap
        ins_req = 1'b0;
        for (int i = 0; i < 3; i++) push_one(32'h1000 + 32'(i * 4), ALU, 1'b1);
        check("stream_prefill", 32'(count_o), 3);
        ins_req = 1'b1;
        for (int i = 3; i < 20; i++) begin
            push_one(32'h1000 + 32'(i * 4), ALU, 1'b1);
            check("stream_count", 32'(count_o), 3);
        end
        repeat (3) tick();
        check("stream_drain", 32'(count_o), 0);

        // Memory-op stall holds the following entry one cycle
        ins_req = 1'b0;
        push_one(32'h40, ALU, 1'b1);
        push_one(32'h44, MEM, 1'b1);
        push_one(32'h48, ALU, 1'b1);
        ins_req = 1'b1;
        tick();
        check("mem_after_alu", 32'(count_o), 2);
        tick();
        check("mem_after_mem", 32'(count_o), 1);
        check("mem_stall_issue", 32'(issue_rdy_o), 0);
        tick();
        check("mem_held_count", 32'(count_o), 1);
        check("mem_resume_issue", 32'(issue_rdy_o), 1);
        check("mem_resume_pc", pc_o, 32'h48);
        tick();
        check("mem_done", 32'(count_o), 0);

        // Flush with simultaneous push and ready
        ins_req = 1'b0;
        for (int i = 0; i < 5; i++) push_one(32'h200 + 32'(i * 4), ALU, 1'b1);
        check("flush_pre", 32'(count_o), 5);
        {push_is_vec_i, push_type_i, push_name_i, push_rd_i, push_pc_i, push_imm_i} = mk(32'h300, ALU);
        push_valid_i = 1'b1;
        flush_i = 1'b1;
        ins_req = 1'b1;
        sb.delete();
        #1;
        check("flush_issue", 32'(issue_rdy_o), 0);
        tick();
        flush_i = 1'b0;
        push_valid_i = 1'b0;
        check("flush_count", 32'(count_o), 0);
        push_one(32'h100, ALU, 1'b1);
        check("post_flush_count", 32'(count_o), 1);
        tick();
        check("post_flush_drain", 32'(count_o), 0);

        // rdy low freezes everything
        ins_req = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h500 + 32'(i * 4), ALU, 1'b1);
        rdy_i = 1'b0;
        ins_req = 1'b1;
        {push_is_vec_i, push_type_i, push_name_i, push_rd_i, push_pc_i, push_imm_i} = mk(32'h600, ALU);
        push_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_count", 32'(count_o), 4);
            check("hold_head", pc_o, 32'h500);
        end
        push_valid_i = 1'b0;
        rdy_i = 1'b1;
        repeat (4) tick();
        check("resume_count", 32'(count_o), 0);

        // Reset mid-operation empties the queue
        ins_req = 1'b0;
        push_one(32'h700, ALU, 1'b0);
        push_one(32'h704, ALU, 1'b0);
        check("pre_rst_count", 32'(count_o), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", 32'(count_o), 0);
        ins_req = 1'b1;
        repeat (2) tick();

        check("sb_leftover", 32'(sb.size()), 0);
        check("issued_total", 32'(n_issued), 36);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
